mem_bus_fabric: RTL and testbench

Parametrised memory-mapped bus fabric between the processor's data port and N memory/peripheral slaves. It succeeds the fixed chip-select/4:1 read-mux arrangement with the following:
- a configurable region table and per-region offset translation;
- a registered request/acknowledge handshake so slaves may take multiple cycles;
- an access timeout;
- an error response for unmapped addresses.

It sits between the processor's data port and the RAM, image ROM and peripheral blocks.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/mem_bus_fabric_if.sv | 36 +++
 rtl/mem_bus_addr_decode.sv | 41 ++++
 rtl/mem_bus_fabric.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_fabric.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus fabric.
//   state_e          - fabric FSM encoding (IDLE, ACCESS, RESP)
//   TO_CNT_W         - width of the slave-ack timeout counter
//   DEF_SLAVE_BASE   - default region bases, slave 0 in the low word
//                      (RAM 0, image ROM 256, peripherals 512, spare 768)
//   DEF_SLAVE_SIZE   - default region sizes in words
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int TO_CNT_W     = 8;
  localparam int DEF_N_SLAVES = 4;
  localparam int DEF_ADDR_W   = 32;

  localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_BASE =
    {32'd768, 32'd512, 32'd256, 32'd0};
  localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_SIZE =
    {32'd256, 32'd256, 32'd256, 32'd256};

endpackage

// File: rtl/mem_bus_fabric_if.sv
// Bus bundle between the processor data port, the fabric and the slaves.
//   cpu_*  - processor side request/response
//   slv_*  - shared slave side: one-hot select, offset, write data, and
//            per-slave packed read data / acknowledge
// Modports:
//   master - the fabric (drives responses to the CPU and the slave bus)
//   slave  - the surrounding environment (CPU and slaves)
interface mem_bus_fabric_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int N_SLAVES = 4
);
  logic                         cpu_req;
  logic                         cpu_we;
  logic [ADDR_W-1:0]            cpu_addr;
  logic [DATA_W-1:0]            cpu_wdata;
  logic [DATA_W-1:0]            cpu_rdata;
  logic                         cpu_ready;
  logic                         cpu_err;
  logic [N_SLAVES-1:0]          slv_sel;
  logic                         slv_we;
  logic [ADDR_W-1:0]            slv_addr;
  logic [DATA_W-1:0]            slv_wdata;
  logic [N_SLAVES*DATA_W-1:0]   slv_rdata;
  logic [N_SLAVES-1:0]          slv_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );
endinterface

// File: rtl/mem_bus_addr_decode.sv
// Combinational region decoder.
//   addr   - word address from the processor
//   hit    - address falls inside at least one region
//   sel    - one-hot select of the lowest-index matching region
//   offset - addr minus the base of the selected region
module mem_bus_addr_decode
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_SLAVES = DEF_N_SLAVES,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_SIZE = DEF_SLAVE_SIZE
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic                hit,
  output logic [N_SLAVES-1:0] sel,
  output logic [ADDR_W-1:0]   offset
);

  logic [ADDR_W:0] addr_x;
  assign addr_x = {1'b0, addr};

  // Scan from the top index down so the lowest matching index is the
  // last one written and therefore wins on overlap. The extra bit keeps
  // base+size from wrapping at the top of the address space.
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    offset = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr_x >= {1'b0, SLAVE_BASE[i*ADDR_W +: ADDR_W]}) &&
          (addr_x <  ({1'b0, SLAVE_BASE[i*ADDR_W +: ADDR_W]} +
                      {1'b0, SLAVE_SIZE[i*ADDR_W +: ADDR_W]}))) begin
        hit    = 1'b1;
        sel    = N_SLAVES'(1) << i;
        offset = addr - SLAVE_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// Memory-mapped bus fabric: processor data port to N slave regions.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_bus_fabric_if.master; CPU request/response plus the
//          registered slave select/offset/write data and per-slave
//          read data and acknowledge
//
// state  | meaning
// IDLE   | waiting for cpu_req; decode and launch or reject
// ACCESS | slave selected, waiting for its ack or the timeout
// RESP   | one-cycle cpu_ready with cpu_err valid
module mem_bus_fabric
  import mem_bus_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_SLAVES = DEF_N_SLAVES,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_SIZE = DEF_SLAVE_SIZE,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_fabric_if.master  bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  localparam logic [TO_CNT_W:0] TIMEOUT_CMP = (TO_CNT_W + 1)'(TIMEOUT);

  logic [1:0]          state_q,  state_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [N_SLAVES-1:0] sel_q,    sel_d;
  logic                we_q,     we_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;
  logic                ready_q,  ready_d;
  logic                err_q,    err_d;

  logic                dec_hit;
  logic [N_SLAVES-1:0] dec_sel;
  logic [ADDR_W-1:0]   dec_offset;

  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_mux;
  logic                to_expire;

  mem_bus_addr_decode #(
    .ADDR_W     (ADDR_W),
    .N_SLAVES   (N_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SIZE (SLAVE_SIZE)
  ) u_decode (
    .addr   (bus.cpu_addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .offset (dec_offset)
  );

  // Only the selected slave's ack and read data are visible; the select
  // is registered so this is an AND-OR over flops and inputs.
  assign ack_sel = |(bus.slv_ack & sel_q);

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) begin
        rdata_mux = rdata_mux | bus.slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Expires on the cycle the count would reach TIMEOUT.
  assign to_expire = (({1'b0, to_cnt_q} + 1'b1) == TIMEOUT_CMP);

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (bus.cpu_req) begin
          if (dec_hit) begin
            sel_d   = dec_sel;
            we_d    = bus.cpu_we;
            addr_d  = dec_offset;
            wdata_d = bus.cpu_wdata;
            state_d = ST_ACCESS;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        // Ack is checked first so it wins on the expiry cycle.
        if (ack_sel) begin
          if (!we_q) begin
            rdata_d = rdata_mux;
          end
          sel_d   = '0;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else if (to_expire) begin
          sel_d   = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric: default memory map instance plus a
// second instance with overlapping regions 0 and 2.
module tb_mem_bus_fabric;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_fabric_if #(.DATA_W(32), .ADDR_W(32), .N_SLAVES(4)) bus ();
  mem_bus_fabric_if #(.DATA_W(32), .ADDR_W(32), .N_SLAVES(4)) bus2 ();

  mem_bus_fabric #(
    .DATA_W(32), .ADDR_W(32), .N_SLAVES(4),
    .SLAVE_BASE({32'd768, 32'd512, 32'd256, 32'd0}),
    .SLAVE_SIZE({32'd256, 32'd256, 32'd256, 32'd256}),
    .TIMEOUT(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_bus_fabric #(
    .DATA_W(32), .ADDR_W(32), .N_SLAVES(4),
    .SLAVE_BASE({32'd768, 32'd0, 32'd256, 32'd0}),
    .SLAVE_SIZE({32'd256, 32'd256, 32'd256, 32'd256}),
    .TIMEOUT(15)
  ) dut_ovl (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    tick();
    bus.cpu_req   = 1'b0;
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.slv_rdata = '0; bus.slv_ack = '0;
    bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    bus2.slv_rdata = '0; bus2.slv_ack = '0;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_err",   bus.cpu_err,   0);
    chk("rst_sel",   bus.slv_sel,   0);
    chk("rst_we",    bus.slv_we,    0);
    chk("rst_addr",  bus.slv_addr,  0);
    chk("rst_wdata", bus.slv_wdata, 0);

    // Read hit, slave 1 acks in its first ACCESS cycle
    request(1'b0, 32'd260, 32'h0);
    chk("rd_sel",   bus.slv_sel,   4'b0010);
    chk("rd_addr",  bus.slv_addr,  4);
    chk("rd_we",    bus.slv_we,    0);
    chk("rd_ready_early", bus.cpu_ready, 0);
    bus.slv_rdata[1*32 +: 32] = 32'hDEADBEEF;
    bus.slv_ack = 4'b0010;
    tick();
    bus.slv_ack = 4'b0000;
    chk("rd_ready", bus.cpu_ready, 1);
    chk("rd_err",   bus.cpu_err,   0);
    chk("rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("rd_sel_clr", bus.slv_sel, 0);
    tick();
    chk("rd_ready_one", bus.cpu_ready, 0);

    // Wait-state write to slave 0
    bus.slv_rdata[0*32 +: 32] = 32'h0BADF00D;
    request(1'b1, 32'd10, 32'h55);
    for (int k = 0; k < 3; k++) begin
      chk("wr_sel",   bus.slv_sel,   4'b0001);
      chk("wr_we",    bus.slv_we,    1);
      chk("wr_addr",  bus.slv_addr,  10);
      chk("wr_wdata", bus.slv_wdata, 32'h55);
      chk("wr_ready_wait", bus.cpu_ready, 0);
      if (k == 2) bus.slv_ack = 4'b0001;
      tick();
    end
    bus.slv_ack = 4'b0000;
    chk("wr_ready", bus.cpu_ready, 1);
    chk("wr_err",   bus.cpu_err,   0);
    chk("wr_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
    tick();

    // Unmapped read
    request(1'b0, 32'd2000, 32'h0);
    chk("um_sel",   bus.slv_sel,   0);
    chk("um_ready", bus.cpu_ready, 1);
    chk("um_err",   bus.cpu_err,   1);
    chk("um_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    tick();
    chk("um_ready_one", bus.cpu_ready, 0);

    // Ack from slave 3 while slave 0 is selected is ignored
    request(1'b1, 32'd5, 32'h77);
    bus.slv_ack = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ns_ready", bus.cpu_ready, 0);
      chk("ns_sel",   bus.slv_sel,   4'b0001);
    end
    bus.slv_ack = 4'b0001;
    tick();
    bus.slv_ack = 4'b0000;
    chk("ns_done_ready", bus.cpu_ready, 1);
    chk("ns_done_err",   bus.cpu_err,   0);
    tick();

    // Timeout on slave 2: ready in the 16th cycle after acceptance
    request(1'b0, 32'd520, 32'h0);
    chk("to_sel",  bus.slv_sel,  4'b0100);
    chk("to_addr", bus.slv_addr, 8);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("to_ready_wait", bus.cpu_ready, 0);
    end
    chk("to_sel_held", bus.slv_sel, 4'b0100);
    tick();
    chk("to_ready", bus.cpu_ready, 1);
    chk("to_err",   bus.cpu_err,   1);
    chk("to_sel_clr", bus.slv_sel, 0);
    chk("to_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
    tick();

    // Ack on the expiry cycle wins
    request(1'b0, 32'd520, 32'h0);
    for (int k = 1; k <= 14; k++) tick();
    chk("tb_ready_wait", bus.cpu_ready, 0);
    bus.slv_rdata[2*32 +: 32] = 32'hCAFEF00D;
    bus.slv_ack = 4'b0100;
    tick();
    bus.slv_ack = 4'b0000;
    chk("tb_ready", bus.cpu_ready, 1);
    chk("tb_err",   bus.cpu_err,   0);
    chk("tb_rdata", bus.cpu_rdata, 32'hCAFEF00D);
    tick();

    // Reset in the second ACCESS cycle aborts the access
    request(1'b1, 32'd300, 32'h99);
    tick();
    chk("ra_sel_before", bus.slv_sel, 4'b0010);
    rst = 1'b1;
    bus.slv_ack = 4'b0010;
    tick();
    rst = 1'b0;
    bus.slv_ack = 4'b0000;
    chk("ra_sel",   bus.slv_sel,   0);
    chk("ra_ready", bus.cpu_ready, 0);
    chk("ra_err",   bus.cpu_err,   0);
    chk("ra_we",    bus.slv_we,    0);
    chk("ra_addr",  bus.slv_addr,  0);
    chk("ra_wdata", bus.slv_wdata, 0);
    chk("ra_rdata", bus.cpu_rdata, 0);
    tick();
    chk("ra_ready_after", bus.cpu_ready, 0);
    request(1'b0, 32'd770, 32'h0);
    chk("ra_new_sel",  bus.slv_sel,  4'b1000);
    chk("ra_new_addr", bus.slv_addr, 2);
    bus.slv_rdata[3*32 +: 32] = 32'h00001234;
    bus.slv_ack = 4'b1000;
    tick();
    bus.slv_ack = 4'b0000;
    chk("ra_new_ready", bus.cpu_ready, 1);
    chk("ra_new_rdata", bus.cpu_rdata, 32'h00001234);
    tick();

    // Overlapping regions 0 and 2 at base 0: slave 0 wins
    bus2.cpu_req  = 1'b1;
    bus2.cpu_we   = 1'b0;
    bus2.cpu_addr = 32'd3;
    tick();
    bus2.cpu_req  = 1'b0;
    chk("ov_sel",  bus2.slv_sel,  4'b0001);
    chk("ov_addr", bus2.slv_addr, 3);
    bus2.slv_rdata[0*32 +: 32] = 32'hA5A5A5A5;
    bus2.slv_ack = 4'b0101;
    tick();
    bus2.slv_ack = 4'b0000;
    chk("ov_ready", bus2.cpu_ready, 1);
    chk("ov_rdata", bus2.cpu_rdata, 32'hA5A5A5A5);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
